cla_pipe_subtractor: RTL and testbench

Two-stage pipelined carry-lookahead subtractor with valid/ready handshakes on both sides. It computes F = A − B − Bin and produces a borrow-out, for unsigned and two's-complement operands. It sits in the adder library alongside the combinational carry-lookahead adder and serves as the streaming subtract-side datapath for multi-cycle arithmetic units.

---
 rtl/adders_pkg.sv | 18 +
 rtl/cla_slice.sv | 51 +++++
 rtl/cla_pipe_subtractor.sv | 98 +++++++++
 tb/tb_cla_pipe_subtractor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adders_pkg.sv
// Shared definitions for the carry-lookahead adder/subtractor library:
// default width, packed {borrow, diff} result type and the bit-level g/p helper.
package adders_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int CLA_GROUP   = 4;

    typedef struct packed {
        logic                   borrow;
        logic [ADDER_WIDTH-1:0] diff;
    } sub_result_t;

    // Returns {generate, propagate} for one bit position.
    function automatic logic [1:0] gen_prop(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/cla_slice.sv
// W-bit carry-lookahead slice: 4-bit groups whose internal carries are all
// derived directly from the group carry-in, chained group to group.
module cla_slice
    import adders_pkg::*;
#(
    parameter int W = ADDER_WIDTH / 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NG = (W + CLA_GROUP - 1) / CLA_GROUP;
    localparam int WP = NG * CLA_GROUP;

    always_comb begin : lookahead
        logic [WP-1:0] g;
        logic [WP-1:0] p;
        logic [WP:0]   c;
        logic [1:0]    gp;
        logic          g_acc;
        logic          p_acc;
        // Padding bits beyond W keep g=p=0, so c[W] is the true carry-out.
        g     = '0;
        p     = '0;
        c     = '0;
        gp    = '0;
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int i = 0; i < W; i++) begin
            gp   = gen_prop(a[i], b[i]);
            g[i] = gp[1];
            p[i] = gp[0];
        end
        c[0] = cin;
        for (int grp = 0; grp < NG; grp++) begin
            g_acc = 1'b0;
            p_acc = 1'b1;
            for (int k = 0; k < CLA_GROUP; k++) begin
                g_acc = g[grp*CLA_GROUP + k] | (p[grp*CLA_GROUP + k] & g_acc);
                p_acc = p_acc & p[grp*CLA_GROUP + k];
                c[grp*CLA_GROUP + k + 1] = g_acc | (p_acc & c[grp*CLA_GROUP]);
            end
        end
        sum  = p[W-1:0] ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Two-stage pipelined CLA subtractor F = A - B - Bin with valid/ready on both sides.
// Define SUB_OVF_FLAG_EN to add the registered signed-overflow output Ovf.
module cla_pipe_subtractor
    import adders_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] F,
    output logic             Bout,
`ifdef SUB_OVF_FLAG_EN
    output logic             Ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int H = WIDTH / 2;

    logic         s1_valid;
    logic         s2_valid;
    logic         s1_adv;
    logic [H-1:0] s1_diff_lo;
    logic         s1_carry;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_b_hi;
    logic [H-1:0] lo_sum;
    logic         lo_cout;
    logic [H-1:0] hi_sum;
    logic         hi_cout;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !rst && (!s1_valid || s1_adv);
    assign out_valid = s2_valid;

    // Subtract as A + ~B + ~Bin: a carry of 1 at any boundary means "no borrow".
    cla_slice #(.W(H)) u_lo (
        .a    (A[H-1:0]),
        .b    (~B[H-1:0]),
        .cin  (~Bin),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cla_slice #(.W(H)) u_hi (
        .a    (s1_a_hi),
        .b    (~s1_b_hi),
        .cin  (s1_carry),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // NOTE: data registers are reset too, so F/Bout read 0 out of reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_diff_lo <= '0;
            s1_carry   <= 1'b0;
            s1_a_hi    <= '0;
            s1_b_hi    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff_lo <= lo_sum;
                s1_carry   <= lo_cout;
                s1_a_hi    <= A[WIDTH-1:H];
                s1_b_hi    <= B[WIDTH-1:H];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            F        <= '0;
            Bout     <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            Ovf      <= 1'b0;
`endif
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                F    <= {hi_sum, s1_diff_lo};
                Bout <= ~hi_cout;
`ifdef SUB_OVF_FLAG_EN
                Ovf  <= (s1_a_hi[H-1] != s1_b_hi[H-1]) && (hi_sum[H-1] != s1_a_hi[H-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Self-checking bench for cla_pipe_subtractor: directed vectors, backpressure,
// mid-flight reset and a 1000-operand randomized throughput run against a 33-bit model.
module tb_cla_pipe_subtractor;
    import adders_pkg::*;

    localparam int W = ADDER_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         bin = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [W-1:0] f_out;
    logic         bout;
    logic         out_valid;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] f;
        logic         bout;
        logic         ovf;
    } exp_t;

    cla_pipe_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a_in),
        .B         (b_in),
        .Bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (f_out),
        .Bout      (bout),
`ifdef SUB_OVF_FLAG_EN
        .Ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 33-bit unsigned subtraction; overflow from the sign rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        sub_result_t r;
        exp_t        e;
        r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.f    = r.diff;
        e.bout = r.borrow;
        e.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || f_out !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b F=%h Bout=%b, want 0 0 0 0",
                     out_valid, in_ready, f_out, bout);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        e = model(a, b, bi);
        @(negedge clk);
        a_in = a; b_in = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom; bin = ~bi;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: out_valid=%b want 0 one edge after accept", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || f_out !== e.f || bout !== e.bout) begin
            errors++;
            $display("FAIL single_result a=%h b=%h bin=%b: valid=%b F=%h Bout=%b, want 1 %h %b",
                     a, b, bi, out_valid, f_out, bout, e.f, e.bout);
        end
`ifdef SUB_OVF_FLAG_EN
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL single_ovf a=%h b=%h bin=%b: Ovf=%b want %b", a, b, bi, ovf, e.ovf);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e [3];
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        for (int i = 0; i < 3; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
            e[i]  = model(av[i], bv[i], 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b0;
        bin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = av[i]; b_in = bv[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_in_ready op%0d: in_ready=%b want %b", i, in_ready, i < 2);
            end
            if (i < 2) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || f_out !== e[0].f || bout !== e[0].bout || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: valid=%b F=%h Bout=%b in_ready=%b, want 1 %h %b 0",
                         k, out_valid, f_out, bout, in_ready, e[0].f, e[0].bout);
            end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release: in_ready=%b want 1 same cycle as out_ready", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || f_out !== e[i].f || bout !== e[i].bout) begin
                errors++;
                $display("FAIL bp_drain res%0d: valid=%b F=%h Bout=%b, want 1 %h %b",
                         i, out_valid, f_out, bout, e[i].f, e[i].bout);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || f_out !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: valid=%b in_ready=%b F=%h Bout=%b, want 0 0 0 0",
                     out_valid, in_ready, f_out, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_release_ready: in_ready=%b want 1", in_ready);
        end
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midflight_stale: out_valid high in %0d cycles, want 0", stale);
        end
    endtask

    task automatic test_throughput();
        exp_t sb [$];
        exp_t e;
        int   sent = 0;
        int   results = 0;
        int   cycles = 0;
        while (results < 1000 && cycles < 1100) begin
            @(negedge clk);
            cycles++;
            if (sent < 1000) begin
                in_valid = 1'b1;
                a_in = $urandom;
                b_in = (sent % 97 == 0) ? a_in : $urandom;
                bin  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tp_unexpected: result F=%h with no operand outstanding", f_out);
                end else begin
                    e = sb.pop_front();
                    if (f_out !== e.f || bout !== e.bout
`ifdef SUB_OVF_FLAG_EN
                        || ovf !== e.ovf
`endif
                    ) begin
                        errors++;
                        $display("FAIL tp_result #%0d: F=%h Bout=%b, want %h %b", results, f_out, bout, e.f, e.bout);
                    end
                end
                results++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a_in, b_in, bin));
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (results != 1000 || cycles != 1002) begin
            errors++;
            $display("FAIL tp_rate: %0d results in %0d cycles, want 1000 in 1002", results, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single(32'd100, 32'd50, 1'b0);
        test_single(32'd0, 32'd1, 1'b0);
        test_single(32'h8000_0000, 32'd1, 1'b0);
        test_single(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        test_single(32'h0001_0000, 32'd0, 1'b1);
        test_single(32'd0, 32'd0, 1'b1);
        test_single(32'h1234_5678, 32'h1234_5678, 1'b0);
        test_backpressure();
        test_reset_midflight();
        test_throughput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
